// File: rtl/pipe_mem_pkg.sv
// Shared constants for the pipelined CPU memory-port arbiter: state encoding and default sizes.
package pipe_mem_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF   = 7;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'b00;
  localparam state_t DATA  = 2'b01;
  localparam state_t FETCH = 2'b10;

endpackage

// File: rtl/pipe_mem_arbiter_if.sv
// CPU fetch/data ports plus the unified memory port, bundled for the arbiter.
interface pipe_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_inst;
  logic              if_done;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_stall;

  logic              bus_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Arbiter side: serves the CPU ports and masters the memory port.
  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_inst, if_done, if_stall, d_rdata, d_done, d_stall, bus_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // Environment side: CPU pipeline and memory model.
  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_inst, if_done, if_stall, d_rdata, d_done, d_stall, bus_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_watchdog.sv
// Bus watchdog: counts stalled memory cycles and flags the edge on which the access must abort.
module mem_watchdog
  import pipe_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over run so the abort edge itself leaves the counter at zero.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire = run & (cnt_q == LAST);

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates the IF fetch port and MEM data port onto one variable-latency memory port.
// Data has fixed priority; a watchdog aborts hung accesses with a bus_err pulse.
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input logic                clk,
  input logic                clr,
  pipe_mem_arbiter_if.master bus
);

  state_t state_q, state_d;

  logic              busy;
  logic              run;
  logic              expire;
  logic              complete;
  logic              grant;
  logic              d_elig;
  logic              if_elig;
  logic              data_end;
  logic              fetch_end;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] rd_result;

  assign busy     = (state_q != IDLE);
  assign run      = busy & ~bus.mem_ready;
  assign complete = busy & (bus.mem_ready | expire);

  // A port whose done pulse is high is still holding its request; don't re-grant it.
  assign d_elig  = bus.d_req & ~bus.d_done;
  assign if_elig = bus.if_req & ~bus.if_done;
  assign grant   = (state_q == IDLE) & (d_elig | if_elig);

  assign data_end  = complete & (state_q == DATA);
  assign fetch_end = complete & (state_q == FETCH);

  assign grant_addr = d_elig ? bus.d_addr : bus.if_addr;
  assign rd_result  = expire ? '0 : bus.mem_rdata;

  assign bus.d_stall  = bus.d_req & ~bus.d_done;
  assign bus.if_stall = bus.if_req & ~bus.if_done;

  mem_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .clr    (clr),
    .run    (run),
    .clear  (complete),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_elig) begin
          state_d = DATA;
        end else if (if_elig) begin
          state_d = FETCH;
        end
      end
      DATA, FETCH: begin
        if (complete) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_done   <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.bus_err   <= 1'b0;
      bus.if_inst   <= '0;
      bus.d_rdata   <= '0;
    end else begin
      state_q     <= state_d;
      bus.if_done <= fetch_end;
      bus.d_done  <= data_end;
      bus.bus_err <= expire;

      // Memory request fields are captured at grant and held until the access ends.
      if (grant) begin
        bus.mem_req  <= 1'b1;
        bus.mem_addr <= grant_addr;
        bus.mem_we   <= d_elig & bus.d_we;
        if (d_elig) begin
          bus.mem_wdata <= bus.d_wdata;
        end
      end else if (complete) begin
        bus.mem_req <= 1'b0;
        bus.mem_we  <= 1'b0;
      end

      if (fetch_end) begin
        bus.if_inst <= rd_result;
      end
      if (data_end && !bus.mem_we) begin
        bus.d_rdata <= rd_result;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Scoreboard bench for pipe_mem_arbiter: directed scenarios then randomized fetch/data traffic.
module tb_pipe_mem_arbiter;
  import pipe_mem_pkg::*;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 7;

  logic clk = 1'b0;
  logic clr = 1'b1;

  pipe_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  pipe_mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO),
    .CNT_W   (CW)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int unsigned lat_cyc;
  } exp_t;

  exp_t d_q[$];
  exp_t f_q[$];

  // Memory latency: forced in directed tests, else taken from address bits [11:8].
  int lat_force = -1;

  function automatic int unsigned lat_of(input logic [31:0] a);
    if (lat_force >= 0) return unsigned'(lat_force);
    return {28'd0, a[11:8]};
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model state: memory as the CPU should observe it, and the d_rdata register.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ref_d_rdata = '0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Memory model driven by the bench.
  logic [31:0] mem_wr [logic [31:0]];
  logic        in_acc = 1'b0;
  logic [31:0] acc_addr = '0;
  logic [31:0] acc_wdata = '0;
  logic        acc_we = 1'b0;
  int unsigned acc_start = 0;
  int unsigned waited = 0;
  int unsigned cyc = 0;
  int unsigned last_d_cyc = 0;
  int unsigned last_f_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (!in_acc) begin
          in_acc    = 1'b1;
          acc_addr  = bus.mem_addr;
          acc_we    = bus.mem_we;
          acc_wdata = bus.mem_wdata;
          acc_start = cyc;
          waited    = 0;
        end else begin
          chk("mem_addr_stable", bus.mem_addr, acc_addr);
          chk("mem_we_stable", {31'd0, bus.mem_we}, {31'd0, acc_we});
          chk("mem_wdata_stable", bus.mem_wdata, acc_wdata);
        end
        if (waited == lat_of(acc_addr)) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem_wr.exists(acc_addr) ? mem_wr[acc_addr] : init_word(acc_addr);
          if (acc_we) mem_wr[acc_addr] = acc_wdata;
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
        end
        waited++;
      end else begin
        in_acc        = 1'b0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
    end
  end

  // Monitor: pops the expectation for whichever port signals done.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!clr) begin
        chk("if_stall", {31'd0, bus.if_stall}, {31'd0, bus.if_req & ~bus.if_done});
        chk("d_stall", {31'd0, bus.d_stall}, {31'd0, bus.d_req & ~bus.d_done});
        if (bus.d_done) begin
          last_d_cyc = cyc;
          if (d_q.size() == 0) begin
            chk("unexpected_d_done", 32'd1, 32'd0);
          end else begin
            e = d_q.pop_front();
            chk("d_bus_err", {31'd0, bus.bus_err}, {31'd0, e.err});
            chk("d_rdata", bus.d_rdata, e.rdata);
            chk("d_mem_addr", acc_addr, e.addr);
            chk("d_mem_we", {31'd0, acc_we}, {31'd0, e.we});
            if (e.we) chk("d_mem_wdata", acc_wdata, e.wdata);
            chk("d_latency", cyc - acc_start, e.lat_cyc);
            chk("d_mem_req_low", {31'd0, bus.mem_req}, 32'd0);
          end
        end
        if (bus.if_done) begin
          last_f_cyc = cyc;
          if (f_q.size() == 0) begin
            chk("unexpected_if_done", 32'd1, 32'd0);
          end else begin
            e = f_q.pop_front();
            chk("if_bus_err", {31'd0, bus.bus_err}, {31'd0, e.err});
            chk("if_inst", bus.if_inst, e.rdata);
            chk("if_mem_addr", acc_addr, e.addr);
            chk("if_mem_we", {31'd0, acc_we}, 32'd0);
            chk("if_latency", cyc - acc_start, e.lat_cyc);
            chk("if_mem_req_low", {31'd0, bus.mem_req}, 32'd0);
          end
        end
        if (bus.bus_err && !bus.d_done && !bus.if_done) chk("bus_err_alone", 32'd1, 32'd0);
      end
    end
  end

  task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int unsigned lat;
    bit          seen;
    lat       = lat_of(addr);
    e.addr    = addr;
    e.we      = we;
    e.wdata   = wdata;
    e.err     = (lat >= TO);
    e.lat_cyc = e.err ? TO : lat + 1;
    if (we) begin
      if (!e.err) ref_mem[addr] = wdata;
    end else begin
      ref_d_rdata = e.err ? 32'd0 : ref_read(addr);
    end
    e.rdata = ref_d_rdata;
    @(posedge clk);
    #1;
    d_q.push_back(e);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.d_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("d_done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'($urandom_range(0, 1));
    bus.d_addr  = $urandom;
    bus.d_wdata = $urandom;
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    exp_t        e;
    int unsigned lat;
    bit          seen;
    lat       = lat_of(addr);
    e.addr    = addr;
    e.we      = 1'b0;
    e.wdata   = '0;
    e.err     = (lat >= TO);
    e.lat_cyc = e.err ? TO : lat + 1;
    e.rdata   = e.err ? 32'd0 : ref_read(addr);
    @(posedge clk);
    #1;
    f_q.push_back(e);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.if_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("if_done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.if_req  = 1'b0;
    bus.if_addr = $urandom;
  endtask

  function automatic logic [3:0] pick_lat();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6) return 4'($urandom_range(0, 3));
    if (r < 8) return 4'($urandom_range(6, 9));
    return 4'd15;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected $finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_if_done", {31'd0, bus.if_done}, 32'd0);
    chk("rst_d_done", {31'd0, bus.d_done}, 32'd0);
    chk("rst_bus_err", {31'd0, bus.bus_err}, 32'd0);
    chk("rst_if_inst", bus.if_inst, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    // Fetch only, three wait cycles.
    lat_force = 3;
    do_fetch(32'h0000_0040);

    // Collision on zero-wait memory: data first, fetch after one IDLE cycle.
    lat_force = 0;
    fork
      do_data(1'b0, 32'h0000_0100, 32'h0);
      do_fetch(32'h0000_0044);
    join
    chk("collision_gap", last_f_cyc - last_d_cyc, 32'd2);

    // Store leaves d_rdata alone; reading it back returns the stored word.
    lat_force = 2;
    do_data(1'b1, 32'h0000_0200, 32'hDEAD_BEEF);
    lat_force = 0;
    do_data(1'b0, 32'h0000_0200, 32'h0);

    // Hung load aborts; ready on the expiry edge completes normally.
    lat_force = 15;
    do_data(1'b0, 32'h0000_0300, 32'h0);
    lat_force = 7;
    do_data(1'b0, 32'h0000_0304, 32'h0);

    // Reset in the middle of a fetch wait.
    lat_force = 15;
    @(posedge clk);
    #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0500;
    repeat (4) @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk("rst_async_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_async_if_inst", bus.if_inst, 32'd0);
    ref_d_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_if_done", {31'd0, bus.if_done}, 32'd0);
    end
    bus.if_req = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    chk("post_rst_no_if_done", {31'd0, bus.if_done}, 32'd0);
    lat_force = 1;
    do_fetch(32'h0000_0600);

    // Randomized traffic on both ports at once.
    lat_force = -1;
    fork
      for (int i = 0; i < 150; i++) begin
        logic [3:0] lat;
        logic [5:0] idx;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        lat = pick_lat();
        idx = 6'($urandom_range(0, 15));
        do_data(($urandom_range(0, 2) == 0), {16'h0, 4'h0, lat, idx, 2'b00}, $urandom);
      end
      for (int j = 0; j < 150; j++) begin
        logic [3:0] lat;
        logic [5:0] idx;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        lat = pick_lat();
        idx = 6'($urandom_range(0, 63));
        do_fetch({16'h0, 4'h1, lat, idx, 2'b00});
      end
    join

    repeat (5) @(negedge clk);
    chk("d_queue_drained", d_q.size(), 32'd0);
    chk("f_queue_drained", f_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares one unified, variable-latency memory port between the pipelined CPU's IF-stage fetch port and MEM-stage data port (lw/sw).
- Data port has fixed priority over fetch, because the older instruction must retire first.
- Produces per-port stall signals that gate pipepc/pipeir and MEM-stage progress, in the same way the ID stage uses nostall.
- Includes a bus watchdog that aborts a hung memory transaction and flags an error.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data/instruction width
TIMEOUT, 64, max cycles waiting for mem_ready before abort (>=2)
CNT_W, 7, watchdog counter width (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
clr  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request; held until if_done
if_addr  in  ADDR_W  fetch address (pc)
if_inst  out  DATA_W  fetched instruction, valid when if_done
if_done  out  1  one-cycle fetch completion pulse
if_stall  out  1  if_req & ~if_done (combinational)
d_req  in  1  data request; held until d_done
d_we  in  1  1=sw, 0=lw
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid when d_done
d_done  out  1  one-cycle data completion pulse
d_stall  out  1  d_req & ~d_done (combinational)
bus_err  out  1  one-cycle pulse with the done pulse of an aborted access
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  registered address
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completes access at this edge when mem_req=1

Behaviour:
- Reset: one clock; asynchronous, active-high reset `clr`.
  - While clr=1, immediately: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_done=0, d_done=0, bus_err=0, if_inst=0, d_rdata=0, watchdog=0.
  - Reset during an access abandons it; no done pulse is produced.
- FSM states: IDLE, DATA, FETCH.
- IDLE:
  - An eligible d_req moves to DATA, latching d_addr/d_we/d_wdata into mem_*, and sets mem_req=1 at that edge.
  - Otherwise an eligible if_req moves to FETCH, latching if_addr, mem_we=0, mem_req=1.
  - Simultaneous requests: DATA always wins.
  - A request is not eligible in the cycle its own done pulse is high; this prevents re-grant of a completing access.
- DATA/FETCH:
  - mem_req and mem_addr/mem_we/mem_wdata are held stable until completion.
  - At an edge with mem_ready=1, go to IDLE with mem_req<=0, and pulse the port's done for 1 cycle.
  - DATA completion: d_rdata<=mem_rdata when mem_we=0; d_rdata is unchanged for a store.
  - FETCH completion: if_inst<=mem_rdata.
- Watchdog:
  - Counts edges in DATA/FETCH with mem_ready=0; cleared on entry to IDLE.
  - When the count reaches TIMEOUT-1 and mem_ready=0 at the next edge, the access aborts: go to IDLE, mem_req<=0, done pulse, bus_err pulse, read result <=0.
  - mem_ready=1 on the abort edge counts as a normal completion (no error).
- Latency:
  - Request seen in IDLE at edge t gives mem_req=1 after t.
  - Earliest mem_ready at edge t+1 gives done high during cycle t+1..t+2.
  - Minimum 2 cycles per access; a one-cycle IDLE gap between back-to-back grants.
- done, rdata, if_inst and bus_err are registered; done and bus_err are never high for more than one cycle.
- Stalls: d_stall/if_stall are combinational from req/done. The pipeline freezes all stages while d_stall=1, so fetch cannot starve. No fairness counter is required.
- Requester protocol violation (req dropped mid-access): the access still completes on memory; the done pulse is still produced and may be ignored.
- mem_we is never 1 in FETCH.

Decomposition:
- Shared package `pipe_mem_pkg`:
  - state encoding localparams (IDLE=2'b00, DATA=2'b01, FETCH=2'b10)
  - default ADDR_W/DATA_W
  - TIMEOUT default
- One sub-module, `mem_watchdog`: inputs clk, clr, run (busy & ~mem_ready), clear. Output `expire`, high when the count equals TIMEOUT-1 and run=1.
- Everything else, including the FSM, is in the top module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x00000040, memory ready 3 cycles after mem_req with rdata 0x8C220004 -> mem_addr=0x40, mem_we=0; if_done one cycle; if_inst=0x8C220004; if_stall low after done.
- Collision: if_req and d_req (lw, addr 0x100) rise in the same cycle, zero-wait memory -> data granted first; d_rdata=mem[0x100]; fetch granted after one IDLE cycle; if_stall high throughout.
- Store: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF held until mem_ready; d_done pulses; d_rdata unchanged.
- Watchdog: TIMEOUT=8, mem_ready stuck 0 on a lw -> abort 8 cycles after mem_req rises; d_done=bus_err=1 for one cycle; d_rdata=0; mem_req=0.
- Boundary: mem_ready rises exactly on the expiry edge -> normal completion, bus_err=0, data from mem_rdata.
- Reset mid-access: assert clr during FETCH wait -> mem_req drops immediately (asynchronously); no if_done pulse; after release, a new if_req is serviced normally.
